sdram_controller: RTL and testbench
===================================

SDRAM_CONTROLLER -- requirements
Module: sdram_controller

Interface
REQ-001 The block SHALL have parameter T_RCD, default 2, giving cycles from ACTIVATE to READ/WRITE.
REQ-002 The block SHALL have parameter CAS_LATENCY, default 2, giving cycles from READ to bank_rdata valid.
REQ-003 The block SHALL have parameter T_RP, default 2, giving cycles from PRECHARGE to the next command.
REQ-004 The block SHALL have parameter T_RFC, default 7, giving cycles from REFRESH to the next command (66 ns).
REQ-005 The block SHALL have parameter REFRESH_INTERVAL, default 1023, giving cycles between refresh requests.
REQ-006 The block SHALL have one clock; reset SHALL be asynchronous and active-high, with ports named clock and reset.
REQ-007 The block SHALL have clock  in  1  system clock.
REQ-008 The block SHALL have reset  in  1  asynchronous active-high reset.
REQ-009 For N=0,1 the block SHALL have reqN  in  1  access request, held until ackN.
REQ-010 For N=0,1 the block SHALL have weN  in  1  1=write, 0=read.
REQ-011 For N=0,1 the block SHALL have addrN  in  22  word address, with row=[21:9] and col=[8:0].
REQ-012 For N=0,1 the block SHALL have wdataN  in  32  write data.
REQ-013 For N=0,1 the block SHALL have rdataN  out  32  read data, valid while ackN=1.
REQ-014 For N=0,1 the block SHALL have ackN  out  1  one-cycle completion pulse.
REQ-015 The block SHALL have cmd_activate, cmd_read, cmd_write, cmd_precharge, cmd_refresh  out  1 each  one-hot bank commands.
REQ-016 The block SHALL have bank_row  out  13  and  bank_col  out  9  command address.
REQ-017 The block SHALL have bank_wdata  out  32  write data, valid with cmd_write.
REQ-018 The block SHALL have bank_rdata  in  32  bank read data.
REQ-019 The block SHALL have bank_wait  in  1  bank busy (stall).

Function
REQ-020 All outputs SHALL be registered, and at most one cmd_* SHALL be high in any cycle, each for exactly one cycle per command.
REQ-021 The FSM states SHALL be IDLE, ACTIVATE, RCD_WAIT, ACCESS, CAS_WAIT, PRECHARGE, RP_WAIT, REFRESH, RFC_WAIT.
REQ-022 Under a closed-page policy, every access SHALL be ACTIVATE -> READ/WRITE -> PRECHARGE.
REQ-023 A free-running refresh counter SHALL wrap from REFRESH_INTERVAL-1 to 0 and set refresh_pending on wrap.
REQ-024 A wrap while refresh_pending is already set SHALL leave the flag set, not counted.
REQ-025 In IDLE, refresh_pending SHALL take priority over any request: cmd_refresh next cycle, refresh_pending cleared in that cycle, then T_RFC-1 RFC_WAIT cycles, then IDLE.
REQ-026 In IDLE with no refresh pending and one reqN high, that port SHALL be granted.
REQ-027 In IDLE with both req high, the port not granted last SHALL be granted (round-robin); last_grant SHALL reset to 1, so port 0 wins first.
REQ-028 The granted addr/we/wdata SHALL be latched at grant; later changes to requester inputs SHALL be ignored.
REQ-029 Read timing SHALL be: grant in cycle n, cmd_activate at n+1, cmd_read at n+1+T_RCD, bank_rdata captured and ackN=1 with rdataN at n+1+T_RCD+CAS_LATENCY, and cmd_precharge the following cycle.
REQ-030 Write timing SHALL be: cmd_write (with bank_wdata) at n+1+T_RCD, ackN at the next cycle, and cmd_precharge the cycle after ackN.
REQ-031 After cmd_precharge the block SHALL wait T_RP-1 cycles in RP_WAIT, then return to IDLE; with defaults the block SHALL be idle 8 cycles after a read grant and 7 after a write grant.
REQ-032 While bank_wait=1, the block SHALL issue no command, wait counters SHALL freeze, and the pending command SHALL issue in the first cycle with bank_wait=0.
REQ-033 Reqs SHALL be sampled only in IDLE; a req still high after its ack SHALL be treated as a new request.
REQ-034 rdataN SHALL hold its last value when ackN=0, and the non-granted port's ack SHALL stay 0.
REQ-035 bank_row/bank_col SHALL carry the latched address with ACTIVATE/READ/WRITE and SHALL hold otherwise.

Reset
REQ-036 Asserting reset SHALL immediately force state IDLE, all outputs 0, refresh counter 0, refresh_pending 0, last_grant 1.
REQ-037 Reset mid-access SHALL abort the access with no ack and no further command.

Verification
REQ-038 Single read, port 0, addr0=22'h00_0205, bank_rdata=32'hDEADBEEF -> activate row 1 at n+1, read col 5 at n+3, ack0 with rdata0=DEADBEEF at n+5, precharge at n+6.
REQ-039 Write on port 1, wdata1=32'h12345678 -> cmd_write at n+3 with bank_wdata=12345678, ack1 at n+4, precharge at n+5.
REQ-040 req0 and req1 high continuously -> grants alternate 0,1,0,1, and no port receives two consecutive acks.
REQ-041 Refresh pending coincident with req0 in IDLE -> cmd_refresh issued first, req0 activated 7 cycles later, and refresh repeats every 1023 cycles.
REQ-042 bank_wait high for 3 cycles during RCD_WAIT -> cmd_read delayed by exactly 3 cycles.
REQ-043 reset pulsed between cmd_read and ack -> no ack, all cmd_* 0, and the next request is served from IDLE normally.

Source files
------------

// File: rtl/sdram_controller.sv
// Closed-page SDRAM controller: two round-robin requesters, periodic refresh,
// bank_wait stall; every output is registered.
module sdram_controller #(
    parameter  int unsigned T_RCD            = 2,
    parameter  int unsigned CAS_LATENCY      = 2,
    parameter  int unsigned T_RP             = 2,
    parameter  int unsigned T_RFC            = 7,
    parameter  int unsigned REFRESH_INTERVAL = 1023,
    localparam int unsigned ADDR_W           = 22,
    localparam int unsigned ROW_W            = 13,
    localparam int unsigned COL_W            = 9,
    localparam int unsigned DATA_W           = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic              cmd_activate,
    output logic              cmd_read,
    output logic              cmd_write,
    output logic              cmd_precharge,
    output logic              cmd_refresh,
    output logic [ROW_W-1:0]  bank_row,
    output logic [COL_W-1:0]  bank_col,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata,
    input  logic              bank_wait
);
    localparam int unsigned CNT_W = $clog2(T_RCD + CAS_LATENCY + T_RP + T_RFC + 1);
    localparam int unsigned RC_W  = $clog2(REFRESH_INTERVAL + 1);

    typedef enum logic [3:0] {
        IDLE, ACTIVATE, RCD_WAIT, ACCESS, CAS_WAIT,
        PRECHARGE, RP_WAIT, REFRESH, RFC_WAIT
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RC_W-1:0]   refresh_cnt_q;
    logic              refresh_pending_q;
    logic              last_grant_q;
    logic              port_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              grant1_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic              refresh_wrap_c;
    logic              ack_now_c;

    // Port 1 wins when alone, or when both ask and port 0 was served last.
    assign grant1_c       = req1 & (~req0 | ~last_grant_q);
    assign sel_addr_c     = grant1_c ? addr1 : addr0;
    assign refresh_wrap_c = (refresh_cnt_q == RC_W'(REFRESH_INTERVAL - 1));
    // Ack lands in the last CAS_WAIT cycle; writes behave as a one-cycle CAS.
    assign ack_now_c = ~bank_wait &
                       (((state_q == ACCESS) & (cnt_q == '0)) |
                        ((state_q == CAS_WAIT) & (cnt_q == CNT_W'(1))));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            refresh_cnt_q     <= '0;
            refresh_pending_q <= 1'b0;
            last_grant_q      <= 1'b1;
            port_q            <= 1'b0;
            we_q              <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            rdata0            <= '0;
            rdata1            <= '0;
            ack0              <= 1'b0;
            ack1              <= 1'b0;
            cmd_activate      <= 1'b0;
            cmd_read          <= 1'b0;
            cmd_write         <= 1'b0;
            cmd_precharge     <= 1'b0;
            cmd_refresh       <= 1'b0;
            bank_row          <= '0;
            bank_col          <= '0;
            bank_wdata        <= '0;
        end else begin
            cmd_activate  <= 1'b0;
            cmd_read      <= 1'b0;
            cmd_write     <= 1'b0;
            cmd_precharge <= 1'b0;
            cmd_refresh   <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            refresh_cnt_q <= refresh_wrap_c ? '0 : refresh_cnt_q + RC_W'(1);

            // A stalled bank freezes the sequencer and its timers.
            if (!bank_wait) begin
                unique case (state_q)
                    IDLE: begin
                        if (refresh_pending_q) begin
                            cmd_refresh       <= 1'b1;
                            refresh_pending_q <= 1'b0;
                            cnt_q             <= CNT_W'(T_RFC - 1);
                            state_q           <= REFRESH;
                        end else if (req0 | req1) begin
                            port_q       <= grant1_c;
                            last_grant_q <= grant1_c;
                            we_q         <= grant1_c ? we1 : we0;
                            wdata_q      <= grant1_c ? wdata1 : wdata0;
                            addr_q       <= sel_addr_c;
                            bank_row     <= sel_addr_c[ADDR_W-1:COL_W];
                            bank_col     <= sel_addr_c[COL_W-1:0];
                            cmd_activate <= 1'b1;
                            cnt_q        <= CNT_W'(T_RCD - 1);
                            state_q      <= ACTIVATE;
                        end
                    end
                    ACTIVATE, RCD_WAIT: begin
                        if (cnt_q == '0) begin
                            bank_row <= addr_q[ADDR_W-1:COL_W];
                            bank_col <= addr_q[COL_W-1:0];
                            if (we_q) begin
                                cmd_write  <= 1'b1;
                                bank_wdata <= wdata_q;
                                cnt_q      <= '0;
                            end else begin
                                cmd_read <= 1'b1;
                                cnt_q    <= CNT_W'(CAS_LATENCY - 1);
                            end
                            state_q <= ACCESS;
                        end else begin
                            cnt_q   <= cnt_q - CNT_W'(1);
                            state_q <= RCD_WAIT;
                        end
                    end
                    ACCESS: state_q <= CAS_WAIT;
                    CAS_WAIT: begin
                        if (cnt_q == '0) begin
                            cmd_precharge <= 1'b1;
                            cnt_q         <= CNT_W'(T_RP - 1);
                            state_q       <= PRECHARGE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    PRECHARGE, RP_WAIT: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q - CNT_W'(1);
                            state_q <= RP_WAIT;
                        end
                    end
                    REFRESH, RFC_WAIT: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q - CNT_W'(1);
                            state_q <= RFC_WAIT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (ack_now_c) begin
                ack0 <= ~port_q;
                ack1 <= port_q;
                if (!we_q) begin
                    if (port_q) rdata1 <= bank_rdata;
                    else        rdata0 <= bank_rdata;
                end
            end

            // A wrap always (re)arms the request, even on the cycle it is consumed.
            if (refresh_wrap_c) refresh_pending_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_controller.sv
// Self-checking bench for sdram_controller: directed timing scenarios plus
// randomized traffic against a tick-schedule reference model.
module tb_sdram_controller;
    localparam int unsigned T_RCD = 2;
    localparam int unsigned CL    = 2;
    localparam int unsigned T_RP  = 2;
    localparam int unsigned T_RFC = 7;
    localparam int unsigned RI    = 1023;
    localparam int OP_RD = 0, OP_WR = 1, OP_REF = 2;
    localparam logic [4:0] C_ACT = 5'b10000, C_RD = 5'b01000, C_WR = 5'b00100,
                           C_PRE = 5'b00010, C_REF = 5'b00001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0, we0, ack0, req1, we1, ack1;
    logic [21:0] addr0, addr1;
    logic [31:0] wdata0, wdata1, rdata0, rdata1;
    logic        cmd_activate, cmd_read, cmd_write, cmd_precharge, cmd_refresh;
    logic [12:0] bank_row;
    logic [8:0]  bank_col;
    logic [31:0] bank_wdata, bank_rdata;
    logic        bank_wait;

    sdram_controller #(.T_RCD(T_RCD), .CAS_LATENCY(CL), .T_RP(T_RP), .T_RFC(T_RFC),
                       .REFRESH_INTERVAL(RI)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .cmd_activate(cmd_activate), .cmd_read(cmd_read), .cmd_write(cmd_write),
        .cmd_precharge(cmd_precharge), .cmd_refresh(cmd_refresh),
        .bank_row(bank_row), .bank_col(bank_col), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .bank_wait(bank_wait)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_errors = 0, cyc = 0;
    bit rand_bank = 1'b1;

    // Reference model: progress ticks since grant, counted only on unstalled edges.
    int          m_rc, m_ticks, m_op;
    bit          m_pend, m_last, m_idle, m_port, m_we;
    logic [21:0] m_addr;
    logic [31:0] m_wdata;
    logic [4:0]  exp_cmd;
    logic [1:0]  exp_ack;
    logic [31:0] exp_rd0, exp_rd1, exp_wdata;
    logic [12:0] exp_row;
    logic [8:0]  exp_col;

    int          t_act = -1, t_rd = -1, t_wr = -1, t_pre = -1, t_ref = -1, t_ref_prev = -1;
    int          t_ack0 = -1, t_ack1 = -1, n_ref = 0;
    logic [12:0] row_at_act;
    logic [8:0]  col_at_rd;
    logic [31:0] wdata_at_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_rc = 0; m_pend = 0; m_last = 1; m_idle = 1; m_ticks = 0; m_op = OP_RD;
        exp_cmd = '0; exp_ack = '0; exp_rd0 = '0; exp_rd1 = '0;
        exp_wdata = '0; exp_row = '0; exp_col = '0;
    endtask

    task automatic model_edge();
        bit wrap;
        wrap    = (m_rc == int'(RI) - 1);
        exp_cmd = '0;
        exp_ack = '0;
        if (!bank_wait) begin
            if (m_idle) begin
                if (m_pend) begin
                    m_op = OP_REF; m_ticks = 1; m_idle = 0; m_pend = 0; exp_cmd = C_REF;
                end else if (req0 || req1) begin
                    m_port  = (req0 && req1) ? ~m_last : req1;
                    m_last  = m_port;
                    m_addr  = m_port ? addr1 : addr0;
                    m_we    = m_port ? we1 : we0;
                    m_wdata = m_port ? wdata1 : wdata0;
                    m_op    = m_we ? OP_WR : OP_RD;
                    m_ticks = 1; m_idle = 0; exp_cmd = C_ACT;
                    exp_row = m_addr[21:9]; exp_col = m_addr[8:0];
                end
            end else begin
                m_ticks++;
                if (m_op == OP_RD) begin
                    if (m_ticks == 1 + T_RCD) begin exp_cmd = C_RD; exp_col = m_addr[8:0]; end
                    if (m_ticks == 1 + T_RCD + CL) begin
                        exp_ack[m_port] = 1'b1;
                        if (m_port) exp_rd1 = bank_rdata; else exp_rd0 = bank_rdata;
                    end
                    if (m_ticks == 2 + T_RCD + CL) exp_cmd = C_PRE;
                    if (m_ticks == 2 + T_RCD + CL + T_RP) m_idle = 1;
                end else if (m_op == OP_WR) begin
                    if (m_ticks == 1 + T_RCD) begin
                        exp_cmd = C_WR; exp_col = m_addr[8:0]; exp_wdata = m_wdata;
                    end
                    if (m_ticks == 2 + T_RCD) exp_ack[m_port] = 1'b1;
                    if (m_ticks == 3 + T_RCD) exp_cmd = C_PRE;
                    if (m_ticks == 3 + T_RCD + T_RP) m_idle = 1;
                end else begin
                    if (m_ticks == 1 + T_RFC) m_idle = 1;
                end
            end
        end
        if (wrap) m_pend = 1;
        m_rc = wrap ? 0 : m_rc + 1;
    endtask

    task automatic compare_outputs();
        chk("cmd", 32'({cmd_activate, cmd_read, cmd_write, cmd_precharge, cmd_refresh}), 32'(exp_cmd));
        chk("ack", 32'({ack1, ack0}), 32'(exp_ack));
        chk("rdata0", rdata0, exp_rd0);
        chk("rdata1", rdata1, exp_rd1);
        chk("bank_row", 32'(bank_row), 32'(exp_row));
        chk("bank_col", 32'(bank_col), 32'(exp_col));
        chk("bank_wdata", bank_wdata, exp_wdata);
    endtask

    task automatic observe();
        if (cmd_activate) begin t_act = cyc; row_at_act = bank_row; end
        if (cmd_read) begin t_rd = cyc; col_at_rd = bank_col; end
        if (cmd_write) begin t_wr = cyc; wdata_at_wr = bank_wdata; end
        if (cmd_precharge) t_pre = cyc;
        if (cmd_refresh) begin t_ref_prev = t_ref; t_ref = cyc; n_ref++; end
        if (ack0) t_ack0 = cyc;
        if (ack1) t_ack1 = cyc;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        if (rand_bank) bank_rdata = $urandom;
        model_edge();
        @(posedge clock);
        #1;
        cyc++;
        compare_outputs();
        observe();
        @(negedge clock);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            compare_outputs();
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_until_ack(input bit port, input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step();
            if (port ? ack1 : ack0) seen = 1'b1;
        end
        if (port) req1 = 1'b0; else req0 = 1'b0;
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && !m_idle; i++) step();
        chk("idle_timeout", 32'(m_idle), 32'd1);
    endtask

    int n0;
    int n_acks;
    bit ack_seq[4];
    bit seen_rd;

    initial begin
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        bank_wait = 0; bank_rdata = '0;
        @(negedge clock);
        do_reset(2);

        // Single read on port 0.
        rand_bank = 1'b0; bank_rdata = 32'hDEADBEEF;
        n0 = cyc; req0 = 1; we0 = 0; addr0 = 22'h00_0205;
        run_until_ack(0, 20, "rd_ack_seen");
        chk("rd_act_time", 32'(t_act), 32'(n0 + 1));
        chk("rd_row", 32'(row_at_act), 32'd1);
        chk("rd_read_time", 32'(t_rd), 32'(n0 + 3));
        chk("rd_col", 32'(col_at_rd), 32'd5);
        chk("rd_ack_time", 32'(t_ack0), 32'(n0 + 5));
        chk("rd_data", rdata0, 32'hDEADBEEF);
        step();
        chk("rd_pre_time", 32'(t_pre), 32'(n0 + 6));
        rand_bank = 1'b1;
        step(); step();

        // Write on port 1, raised exactly 8 cycles after the read grant.
        n0 = cyc; req1 = 1; we1 = 1; wdata1 = 32'h12345678; addr1 = 22'($urandom);
        run_until_ack(1, 20, "wr_ack_seen");
        chk("rd_idle_after_8", 32'(t_act), 32'(n0 + 1));
        chk("wr_write_time", 32'(t_wr), 32'(n0 + 3));
        chk("wr_bank_wdata", wdata_at_wr, 32'h12345678);
        chk("wr_ack_time", 32'(t_ack1), 32'(n0 + 4));
        step();
        chk("wr_pre_time", 32'(t_pre), 32'(n0 + 5));
        step(); step();

        // Both ports request continuously: strict alternation starting at port 0.
        n0 = cyc; req0 = 1; req1 = 1; we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = 22'($urandom); addr1 = 22'($urandom);
        step();
        chk("wr_idle_after_7", 32'(t_act), 32'(n0 + 1));
        n_acks = 0;
        for (int i = 0; i < 120 && n_acks < 4; i++) begin
            step();
            if (ack0 || ack1) begin ack_seq[n_acks] = ack1; n_acks++; end
        end
        req0 = 0; req1 = 0;
        chk("rr_count", 32'(n_acks), 32'd4);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(ack_seq[i]), 32'(i % 2));
        wait_idle();

        // bank_wait held for three cycles during RCD_WAIT.
        n0 = cyc; req0 = 1; we0 = 0; addr0 = 22'($urandom);
        step(); step();
        bank_wait = 1;
        step(); step(); step();
        bank_wait = 0;
        run_until_ack(0, 20, "bw_ack_seen");
        chk("bw_read_delay", 32'(t_rd - t_act), 32'(T_RCD + 3));
        chk("bw_ack_time", 32'(t_ack0), 32'(n0 + 8));
        wait_idle();

        // Reset between cmd_read and ack aborts the access.
        req0 = 1; we0 = 0; addr0 = 22'($urandom); seen_rd = 0;
        for (int i = 0; i < 20 && !seen_rd; i++) begin
            step();
            if (cmd_read) seen_rd = 1;
        end
        chk("rst_read_seen", 32'(seen_rd), 32'd1);
        req0 = 0;
        t_ack0 = -1;
        do_reset(3);
        chk("rst_no_ack", 32'(t_ack0), 32'hFFFF_FFFF);
        n0 = cyc; req1 = 1; we1 = 0; addr1 = 22'($urandom);
        run_until_ack(1, 20, "post_rst_ack_seen");
        chk("post_rst_ack_time", 32'(t_ack1), 32'(n0 + 5));

        // Refresh coincident with a request, then periodic repetition.
        for (int i = 0; i < 1100 && !m_pend; i++) step();
        chk("ref_pending_seen", 32'(m_pend), 32'd1);
        n0 = cyc; req0 = 1; we0 = 0; addr0 = 22'($urandom);
        run_until_ack(0, 40, "ref_ack_seen");
        chk("ref_first", 32'(t_ref), 32'(n0 + 1));
        chk("ref_grant_after", 32'(t_act - 1 - t_ref), 32'(T_RFC));
        n0 = n_ref;
        for (int i = 0; i < 1100 && n_ref == n0; i++) step();
        chk("ref_period", 32'(t_ref - t_ref_prev), 32'(RI));

        // Random traffic with random stalls and changing requester inputs.
        for (int i = 0; i < 3000; i++) begin
            if (ack0 && $urandom_range(0, 1) == 0) req0 = 0;
            if (ack1 && $urandom_range(0, 1) == 0) req1 = 0;
            if (!req0 && $urandom_range(0, 2) == 0) req0 = 1;
            if (!req1 && $urandom_range(0, 2) == 0) req1 = 1;
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = 22'($urandom); addr1 = 22'($urandom);
            wdata0 = $urandom; wdata1 = $urandom;
            bank_wait = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
